uart_fifo_link: RTL and testbench
=================================

// Module: uart_fifo_link
// PURPOSE
//  Parametrised full-duplex UART for the serial debug unit: replaces fixed 8N1 RX/TX pair.
//  Adds TX/RX FIFOs, configurable data width/baud, framing + overflow error flags.
//  Sits between the board rxd/txd pins and the debug command processor's byte handshakes.
// PARAMETERS
//  CLK_FREQ   100_000_000  clk frequency in Hz
//  BAUD       115_200      line rate; DIV = CLK_FREQ/BAUD (integer, >= 16), bit period = DIV clocks
//  DATA_BITS  8            payload bits per frame, legal 5..8, sent LSB first
//  DEPTH      16           entries per FIFO, power of 2, >= 2; AW = $clog2(DEPTH)
// PORTS
//  clk        in   1          system clock
//  rst        in   1          asynchronous reset, active-high
//  rxd        in   1          serial input (async, idle high)
//  txd        out  1          serial output (idle high)
//  tx_data    in   DATA_BITS  byte to transmit
//  tx_vld     in   1          push request into TX FIFO
//  tx_rdy     out  1          TX FIFO not full; push occurs when tx_vld & tx_rdy
//  rx_data    out  DATA_BITS  head of RX FIFO (first-word fall-through)
//  rx_vld     out  1          RX FIFO not empty
//  rx_rdy     in   1          pop; occurs when rx_vld & rx_rdy
//  rx_ovf     out  1          sticky: frame received while RX FIFO full
//  rx_ferr    out  1          sticky: stop bit sampled low (or parity error)
//  err_clr    in   1          synchronous clear of rx_ovf/rx_ferr
//  tx_level   out  AW+1       TX FIFO occupancy, 0..DEPTH
//  rx_level   out  AW+1       RX FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (async, any state): txd=1, tx_rdy=1, rx_vld=0, errs=0, levels=0, FIFOs empty, FSMs IDLE.
//  FIFOs: circular, AW-bit pointers + count; push when full refused (tx_rdy=0); pop when empty ignored.
//   Simultaneous push+pop: level unchanged, legal also when full (RX) / empty-with-bypass not allowed.
//  rxd passes a 2-flop synchroniser (2-cycle input latency) before use.
//  TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, each state DIV clocks.
//   IDLE pops FIFO when non-empty; txd falls on the cycle after the pop (push->start bit <= 2 clk).
//   DATA shifts DATA_BITS bits LSB first; STOP drives 1; back-to-back frames with no idle gap.
//  RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: falling edge of synced rxd starts counter; START re-samples at DIV/2; if high -> IDLE (glitch).
//   DATA/PARITY/STOP sampled every DIV clocks from the start mid-point.
//   STOP sample high: byte pushed to RX FIFO same cycle, rx_vld high next cycle.
//   STOP sample low: byte discarded, rx_ferr=1; FSM waits for rxd high before IDLE.
//   RX FIFO full at push: byte dropped, rx_ovf=1; FIFO contents unchanged.
//  err_clr and a new error in the same cycle: error wins (flag stays 1).
//  Baud counter free-runs only while FSM non-IDLE; reloads 0 on each state change.
// CONFIGURATION
//  UART_PARITY_EN defined: even parity bit inserted after DATA (TX) and checked (RX);
//   mismatch -> byte discarded, rx_ferr=1. Frame = 1+DATA_BITS+1+1 bit periods.
//  Not defined: no PARITY state, frame = 1+DATA_BITS+1 bit periods (8N1 at defaults).
// TESTING  (CLK_FREQ=1_000_000, BAUD=10_000 -> DIV=100, DATA_BITS=8, DEPTH=4)
//  1 push 0x55 idle -> txd 0 for 100 clk, then 1,0,1,0,1,0,1,0 x100 clk, stop 1; frame 1000 clk.
//  2 txd looped to rxd, push 0xA3,0x00,0xFF -> rx pops 0xA3,0x00,0xFF in order, rx_ferr=rx_ovf=0.
//  3 loopback, send 5 frames without popping -> rx_level=4, first 4 bytes kept, rx_ovf=1; err_clr -> 0.
//  4 drive frame 0x3C with stop bit low -> rx_ferr=1, rx_vld stays 0.
//  5 rxd low for 30 clk then high -> no frame, rx_vld=0, FSM back to IDLE.
//  6 rst pulse mid DATA of TX frame, 3 bytes queued -> txd=1 at once, tx_level=0, tx_rdy=1.
//  7 (UART_PARITY_EN) send 0x07 with parity bit 0 -> rx_ferr=1; with 1 -> 0x07 received.

Source files
------------

// File: rtl/uart_fifo_link.sv
// Full-duplex UART with TX/RX FIFOs, sticky framing/overflow flags and a configurable payload width.
// Define UART_PARITY_EN to add an even parity bit after the data bits (inserted on TX, checked on RX).
module uart_fifo_link #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rxd,
  output logic                   txd,
  input  logic [DATA_BITS-1:0]   tx_data,
  input  logic                   tx_vld,
  output logic                   tx_rdy,
  output logic [DATA_BITS-1:0]   rx_data,
  output logic                   rx_vld,
  input  logic                   rx_rdy,
  output logic                   rx_ovf,
  output logic                   rx_ferr,
  input  logic                   err_clr,
  output logic [$clog2(DEPTH):0] tx_level,
  output logic [$clog2(DEPTH):0] rx_level
);

  localparam int AW  = $clog2(DEPTH);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] FULL_TICK = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_TICK = CW'(DIV / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [DEPTH];
  logic [AW-1:0]        tx_wp, tx_rp;
  logic [AW:0]          tx_cnt;
  logic                 tx_push, tx_pop;

  assign tx_rdy   = (tx_cnt != FULL_LVL);
  assign tx_push  = tx_vld & tx_rdy;
  assign tx_level = tx_cnt;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + (AW + 1)'(1);
        2'b01:   tx_cnt <= tx_cnt - (AW + 1)'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] rx_mem [DEPTH];
  logic [AW-1:0]        rx_wp, rx_rp;
  logic [AW:0]          rx_cnt;
  logic                 rx_push, rx_pop;
  logic [DATA_BITS-1:0] rx_shift;

  assign rx_vld   = (rx_cnt != '0);
  assign rx_pop   = rx_vld & rx_rdy;
  assign rx_data  = rx_mem[rx_rp];
  assign rx_level = rx_cnt;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + (AW + 1)'(1);
        2'b01:   rx_cnt <= rx_cnt - (AW + 1)'(1);
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t            tx_state, tx_state_nx;
  logic [CW-1:0]        tx_baud;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_tick;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_tick = (tx_baud == FULL_TICK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_state_nx;
  end

  // STOP reloads straight into START when more data is queued, so frames run back to back.
  always_comb begin
    tx_state_nx = tx_state;
    tx_pop      = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (tx_cnt != '0) begin
          tx_pop      = 1'b1;
          tx_state_nx = TX_START;
        end
      end
      TX_START: if (tx_tick) tx_state_nx = TX_DATA;
      TX_DATA: begin
        if (tx_tick && tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
          tx_state_nx = TX_PARITY;
`else
          tx_state_nx = TX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: if (tx_tick) tx_state_nx = TX_STOP;
`endif
      TX_STOP: begin
        if (tx_tick) begin
          if (tx_cnt != '0) begin
            tx_pop      = 1'b1;
            tx_state_nx = TX_START;
          end else begin
            tx_state_nx = TX_IDLE;
          end
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      if (tx_state == TX_IDLE || tx_tick) tx_baud <= '0;
      else                                tx_baud <= tx_baud + CW'(1);
      if (tx_pop) begin
        tx_shift <= tx_mem[tx_rp];
        tx_bit   <= '0;
`ifdef UART_PARITY_EN
        tx_par   <= ^tx_mem[tx_rp];
`endif
      end else if (tx_state == TX_DATA && tx_tick) begin
        tx_shift <= tx_shift >> 1;
        tx_bit   <= tx_bit + BW'(1);
      end
    end
  end

  always_comb begin
    txd = 1'b1;
    case (tx_state)
      TX_START:  txd = 1'b0;
      TX_DATA:   txd = tx_shift[0];
`ifdef UART_PARITY_EN
      TX_PARITY: txd = tx_par;
`endif
      default:   txd = 1'b1;
    endcase
  end

  // ---------------- RX path ----------------
  logic          rxd_s1, rxd_s2, rxd_s3;
  logic          rx_fall, rx_tick, par_ok, set_ovf, set_ferr;
  rx_state_t     rx_state, rx_state_nx;
  logic [CW-1:0] rx_baud;
  logic [BW-1:0] rx_bit;
`ifdef UART_PARITY_EN
  logic          rx_par;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_s3 <= 1'b1;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
      rxd_s3 <= rxd_s2;
    end
  end

  assign rx_fall = rxd_s3 & ~rxd_s2;
  assign rx_tick = (rx_state == RX_START) ? (rx_baud == HALF_TICK) : (rx_baud == FULL_TICK);
`ifdef UART_PARITY_EN
  assign par_ok  = (rx_par == ^rx_shift);
`else
  assign par_ok  = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_state_nx;
  end

  // A full FIFO still accepts the byte when the consumer pops in the same cycle.
  always_comb begin
    rx_state_nx = rx_state;
    rx_push     = 1'b0;
    set_ovf     = 1'b0;
    set_ferr    = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_state_nx = RX_START;
      RX_START: if (rx_tick) rx_state_nx = rxd_s2 ? RX_IDLE : RX_DATA;
      RX_DATA: begin
        if (rx_tick && rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
          rx_state_nx = RX_PARITY;
`else
          rx_state_nx = RX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: if (rx_tick) rx_state_nx = RX_STOP;
`endif
      RX_STOP: begin
        if (rx_tick) begin
          if (rxd_s2 && par_ok) begin
            rx_state_nx = RX_IDLE;
            if (rx_cnt != FULL_LVL || rx_pop) rx_push = 1'b1;
            else                              set_ovf = 1'b1;
          end else begin
            set_ferr    = 1'b1;
            rx_state_nx = RX_WAIT;
          end
        end
      end
      RX_WAIT:  if (rxd_s2) rx_state_nx = RX_IDLE;
      default:  rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
`ifdef UART_PARITY_EN
      rx_par   <= 1'b0;
`endif
      rx_ovf   <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      if (rx_state == RX_IDLE || rx_state == RX_WAIT || rx_tick) rx_baud <= '0;
      else                                                       rx_baud <= rx_baud + CW'(1);
      if (rx_state == RX_START) begin
        rx_bit <= '0;
      end else if (rx_state == RX_DATA && rx_tick) begin
        rx_shift <= {rxd_s2, rx_shift[DATA_BITS-1:1]};
        rx_bit   <= rx_bit + BW'(1);
      end
`ifdef UART_PARITY_EN
      if (rx_state == RX_PARITY && rx_tick) rx_par <= rxd_s2;
`endif
      // A new error in the same cycle as err_clr keeps the flag set.
      if (set_ovf)      rx_ovf <= 1'b1;
      else if (err_clr) rx_ovf <= 1'b0;
      if (set_ferr)     rx_ferr <= 1'b1;
      else if (err_clr) rx_ferr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_fifo_link.sv
// Directed self-checking bench for uart_fifo_link at DIV=100, 8 data bits, 4-entry FIFOs.
// Parity step and parity-bit timing are included when UART_PARITY_EN is defined.
module tb_uart_fifo_link;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD      = 10_000;
  localparam int DATA_BITS = 8;
  localparam int DEPTH     = 4;
  localparam int DIV       = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd;
  logic       txd;
  logic [7:0] tx_data = 8'h00;
  logic       tx_vld = 1'b0;
  logic       tx_rdy;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       rx_rdy = 1'b0;
  logic       rx_ovf;
  logic       rx_ferr;
  logic       err_clr = 1'b0;
  logic [2:0] tx_level;
  logic [2:0] rx_level;
  logic       rxd_drv = 1'b1;
  logic       loop = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rxd = loop ? txd : rxd_drv;

  uart_fifo_link #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(DATA_BITS), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .txd(txd),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
    .rx_data(rx_data), .rx_vld(rx_vld), .rx_rdy(rx_rdy),
    .rx_ovf(rx_ovf), .rx_ferr(rx_ferr), .err_clr(err_clr),
    .tx_level(tx_level), .rx_level(rx_level)
  );

  task automatic waitClocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Push one byte into the TX FIFO, waiting a bounded time for space.
  task automatic applyStimulus(input logic [7:0] d);
    int i = 0;
    while (!tx_rdy && i < 5000) begin
      @(negedge clk);
      i++;
    end
    checkOutput("tx_rdy before push", 32'(tx_rdy), 32'd1);
    tx_data = d;
    tx_vld  = 1'b1;
    @(negedge clk);
    tx_vld  = 1'b0;
  endtask

  task automatic popExpect(input string tag, input logic [7:0] exp);
    checkOutput({tag, " rx_vld"}, 32'(rx_vld), 32'd1);
    checkOutput({tag, " rx_data"}, 32'(rx_data), 32'(exp));
    rx_rdy = 1'b1;
    @(negedge clk);
    rx_rdy = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic bad_par, input logic stop_bit);
    rxd_drv = 1'b0;
    waitClocks(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      waitClocks(DIV);
    end
`ifdef UART_PARITY_EN
    rxd_drv = (^d) ^ bad_par;
    waitClocks(DIV);
`endif
    rxd_drv = stop_bit;
    waitClocks(DIV);
    rxd_drv = 1'b1;
  endtask

  task automatic waitRxLevel(input string tag, input logic [2:0] target, input int budget);
    int i = 0;
    while (rx_level != target && i < budget) begin
      @(negedge clk);
      i++;
    end
    checkOutput(tag, 32'(rx_level), 32'(target));
  endtask

  initial begin
    logic [7:0] exp_byte;
    int i;

    // Reset state
    waitClocks(3);
    checkOutput("reset txd", 32'(txd), 32'd1);
    checkOutput("reset tx_rdy", 32'(tx_rdy), 32'd1);
    checkOutput("reset rx_vld", 32'(rx_vld), 32'd0);
    checkOutput("reset rx_ovf", 32'(rx_ovf), 32'd0);
    checkOutput("reset rx_ferr", 32'(rx_ferr), 32'd0);
    checkOutput("reset tx_level", 32'(tx_level), 32'd0);
    checkOutput("reset rx_level", 32'(rx_level), 32'd0);
    rst = 1'b0;
    waitClocks(2);

    // 1: frame shape of 0x55, checked on the first cycle of each bit
    $display("[TB] step 1: TX frame 0x55");
    tx_data = 8'h55;
    tx_vld  = 1'b1;
    @(negedge clk);
    tx_vld  = 1'b0;
    checkOutput("t1 level after push", 32'(tx_level), 32'd1);
    checkOutput("t1 txd still idle", 32'(txd), 32'd1);
    @(negedge clk);
    checkOutput("t1 start edge", 32'(txd), 32'd0);
    checkOutput("t1 level after pop", 32'(tx_level), 32'd0);
    waitClocks(99);
    checkOutput("t1 start last cycle", 32'(txd), 32'd0);
    exp_byte = 8'h55;
    waitClocks(1);
    checkOutput("t1 data bit 0", 32'(txd), 32'(exp_byte[0]));
    for (int b = 1; b < 8; b++) begin
      waitClocks(DIV);
      checkOutput($sformatf("t1 data bit %0d", b), 32'(txd), 32'(exp_byte[b]));
    end
`ifdef UART_PARITY_EN
    waitClocks(DIV);
    checkOutput("t1 parity bit", 32'd0 | 32'(txd), 32'd0);
`endif
    waitClocks(DIV);
    checkOutput("t1 stop bit", 32'(txd), 32'd1);
    waitClocks(DIV);
    checkOutput("t1 idle after frame", 32'(txd), 32'd1);

    // 2: loopback order
    $display("[TB] step 2: loopback A3 00 FF");
    loop = 1'b1;
    applyStimulus(8'hA3);
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    waitRxLevel("t2 rx_level", 3'd3, 4000);
    checkOutput("t2 rx_ferr", 32'(rx_ferr), 32'd0);
    checkOutput("t2 rx_ovf", 32'(rx_ovf), 32'd0);
    popExpect("t2 pop0", 8'hA3);
    popExpect("t2 pop1", 8'h00);
    popExpect("t2 pop2", 8'hFF);
    checkOutput("t2 rx empty", 32'(rx_vld), 32'd0);
    waitClocks(150);
    loop = 1'b0;

    // 3: overflow with five frames and no pops
    $display("[TB] step 3: RX overflow");
    loop = 1'b1;
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    applyStimulus(8'h55);
    i = 0;
    while (!rx_ovf && i < 7000) begin
      @(negedge clk);
      i++;
    end
    checkOutput("t3 rx_ovf set", 32'(rx_ovf), 32'd1);
    checkOutput("t3 rx_level", 32'(rx_level), 32'd4);
    checkOutput("t3 rx_ferr", 32'(rx_ferr), 32'd0);
    waitClocks(150);
    checkOutput("t3 tx drained", 32'(tx_level), 32'd0);
    loop = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("t3 rx_ovf cleared", 32'(rx_ovf), 32'd0);
    popExpect("t3 pop0", 8'h11);
    popExpect("t3 pop1", 8'h22);
    popExpect("t3 pop2", 8'h33);
    popExpect("t3 pop3", 8'h44);
    checkOutput("t3 rx empty", 32'(rx_level), 32'd0);

    // 4: stop bit low
    $display("[TB] step 4: framing error");
    sendFrame(8'h3C, 1'b0, 1'b0);
    waitClocks(20);
    checkOutput("t4 rx_ferr", 32'(rx_ferr), 32'd1);
    checkOutput("t4 rx_vld", 32'(rx_vld), 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("t4 rx_ferr cleared", 32'(rx_ferr), 32'd0);

    // 5: 30-clock glitch, then a good frame proves RX is back in IDLE
    $display("[TB] step 5: start-bit glitch");
    rxd_drv = 1'b0;
    waitClocks(30);
    rxd_drv = 1'b1;
    waitClocks(200);
    checkOutput("t5 rx_vld", 32'(rx_vld), 32'd0);
    checkOutput("t5 rx_ferr", 32'(rx_ferr), 32'd0);
    sendFrame(8'h96, 1'b0, 1'b1);
    waitClocks(20);
    checkOutput("t5 rx_level", 32'(rx_level), 32'd1);
    popExpect("t5 pop", 8'h96);

    // 6: async reset mid DATA with 3 bytes queued
    $display("[TB] step 6: reset mid frame");
    applyStimulus(8'h00);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    applyStimulus(8'h56);
    waitClocks(300);
    checkOutput("t6 tx_level before", 32'(tx_level), 32'd3);
    checkOutput("t6 txd data low", 32'(txd), 32'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6 txd after rst", 32'(txd), 32'd1);
    checkOutput("t6 tx_level after rst", 32'(tx_level), 32'd0);
    checkOutput("t6 tx_rdy after rst", 32'(tx_rdy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    waitClocks(200);
    checkOutput("t6 txd stays idle", 32'(txd), 32'd1);
    checkOutput("t6 tx_level stays 0", 32'(tx_level), 32'd0);

`ifdef UART_PARITY_EN
    // 7: parity check on 0x07 (even parity bit is 1)
    $display("[TB] step 7: parity");
    sendFrame(8'h07, 1'b1, 1'b1);
    waitClocks(20);
    checkOutput("t7 bad parity ferr", 32'(rx_ferr), 32'd1);
    checkOutput("t7 bad parity rx_vld", 32'(rx_vld), 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    sendFrame(8'h07, 1'b0, 1'b1);
    waitClocks(20);
    checkOutput("t7 good parity ferr", 32'(rx_ferr), 32'd0);
    popExpect("t7 pop", 8'h07);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
